instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage feeding the microprogrammed controller.
//  - Fetches 32-bit words from instruction memory over a req/ack handshake and holds them in IR.
//  - Presents the 6-bit opcode (op) that the controller's dispatch logic consumes.
//  - Maintains the PC: sequential +4 and branch/jump redirect. Flags memory timeouts.
// PARAMETERS
//  AW       32     PC / memory address width in bits (>= 8)
//  RESET_PC 0      PC value after reset; low 2 bits must be 0
//  TIMEOUT  16     WAIT cycles without mem_ack before entering ERR (2..255)
// PORTS
//  clock        in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-low reset
//  fetch        in   1   controller request for the next instruction (1-cycle pulse)
//  pc_load      in   1   redirect PC to pc_target (branch/jump)
//  pc_target    in   AW  redirect address; bits [1:0] ignored (treated as 0)
//  mem_req      out  1   memory read request, registered
//  mem_addr     out  AW  read address, registered, stable while mem_req=1
//  mem_ack      in   1   read data valid this cycle
//  mem_rdata    in   32  read data, sampled only when mem_req&mem_ack
//  ir           out  32  instruction register
//  op           out  6   ir[31:26]
//  pc           out  AW  address of the next instruction to fetch
//  instr_valid  out  1   ir holds a valid instruction for the controller
//  busy         out  1   1 whenever state != IDLE
//  err          out  1   sticky memory-timeout flag
// BEHAVIOUR
//  - Reset (reset==0 at posedge), all registers:
//    state=IDLE, pc=RESET_PC, ir=0, mem_req=0, mem_addr=0, instr_valid=0, err=0,
//    timer=0, pend_valid=0. Reset mid-WAIT abandons the transaction; a late mem_ack is ignored.
//  - States: IDLE, WAIT, ERR.
//  - IDLE:
//    - fetch=1 -> WAIT next cycle with mem_req=1, mem_addr=pc, instr_valid=0, timer=0.
//    - pc_load=1 (with or without fetch) -> pc<=pc_target&~3, instr_valid=0.
//    - pc_load and fetch in the same cycle -> mem_addr=pc_target&~3.
//  - WAIT:
//    - mem_req held 1; mem_addr held stable.
//    - mem_ack=1, no pending redirect -> ir<=mem_rdata, pc<=mem_addr+4 (mod 2^AW),
//      instr_valid=1, mem_req=0, state IDLE. All of these are visible the cycle after the ack.
//    - pc_load in WAIT -> store target in pend, pend_valid=1; a later pc_load overwrites it.
//    - On the ack with pend_valid=1, or with pc_load in the ack cycle -> data discarded, ir kept,
//      instr_valid=0, pc<=target, pend_valid=0, state IDLE.
//    - fetch in WAIT is ignored and is not queued.
//    - Each WAIT cycle with mem_ack=0 -> timer+1. When timer reaches TIMEOUT-1 with no ack ->
//      state ERR, mem_req=0, err=1. mem_req stays high for exactly TIMEOUT cycles.
//  - ERR: fetch, pc_load and mem_ack are ignored; err stays 1 until reset.
//  - instr_valid stays 1 in IDLE until the next accepted fetch or a pc_load.
//  - op is purely combinational from ir.
//  - Latency: fetch at cycle N -> mem_req=1 at N+1; with ack at cycle M (M>=N+1),
//    ir and instr_valid update at M+1. Zero-wait memory gives 2-cycle fetch.
// TESTING
//  1 Reset with RESET_PC=0 -> pc=0, mem_req=0, instr_valid=0, err=0. Then fetch, ack next cycle
//    with rdata=0x8C220004 -> ir=0x8C220004, op=0x23, pc=4, instr_valid=1.
//  2 pc=0xFFFFFFFC (AW=32), fetch plus ack -> pc wraps to 0x0.
//  3 Same-cycle pc_load=1, pc_target=0x107, fetch=1 -> mem_addr=0x104. After ack, pc=0x108.
//  4 fetch, then pc_load target 0x40 during WAIT, ack with rdata=0x12345678 -> ir unchanged,
//    instr_valid=0, pc=0x40, state IDLE.
//  5 fetch with mem_ack held 0 -> mem_req high for exactly TIMEOUT cycles, then err=1 and busy=1.
//    Later fetch is ignored; reset clears err.
//  6 reset pulsed low mid-WAIT, then mem_ack=1 -> no IR update, pc=RESET_PC, mem_req=0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage: PC, req/ack memory read into IR,
//               branch redirect (immediate or deferred) and timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_fetch,
  input  logic          i_pc_load,
  input  logic [AW-1:0] i_pc_target,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic [31:0]   o_ir,
  output logic [5:0]    o_op,
  output logic [AW-1:0] o_pc,
  output logic          o_instr_valid,
  output logic          o_busy,
  output logic          o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [7:0]    c_TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] c_PC_STEP  = {{(AW-3){1'b0}}, 3'b100};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc,         w_pc_nxt;
  logic [31:0]   r_ir,         w_ir_nxt;
  logic          r_mem_req,    w_mem_req_nxt;
  logic [AW-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic          r_instr_valid, w_instr_valid_nxt;
  logic          r_err,        w_err_nxt;
  logic [7:0]    r_timer,      w_timer_nxt;
  logic [AW-1:0] r_pend,       w_pend_nxt;
  logic          r_pend_valid, w_pend_valid_nxt;

  logic [AW-1:0] w_target;
  logic          w_unused_tgt_lsb;

  // Targets are always word aligned; the two low address bits are dropped.
  assign w_target         = {i_pc_target[AW-1:2], 2'b00};
  assign w_unused_tgt_lsb = ^i_pc_target[1:0];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_err         <= 1'b0;
      r_timer       <= '0;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_err         <= w_err_nxt;
      r_timer       <= w_timer_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ir_nxt          = r_ir;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_valid_nxt = r_instr_valid;
    w_err_nxt         = r_err;
    w_timer_nxt       = r_timer;
    w_pend_nxt        = r_pend;
    w_pend_valid_nxt  = r_pend_valid;

    case (r_state)
      S_IDLE: begin
        if (i_pc_load) begin
          w_pc_nxt          = w_target;
          w_instr_valid_nxt = 1'b0;
        end
        if (i_fetch) begin
          w_state_nxt       = S_WAIT;
          w_mem_req_nxt     = 1'b1;
          w_mem_addr_nxt    = i_pc_load ? w_target : r_pc;
          w_instr_valid_nxt = 1'b0;
          w_timer_nxt       = '0;
          w_pend_valid_nxt  = 1'b0;
        end
      end

      S_WAIT: begin
        if (i_mem_ack) begin
          w_state_nxt      = S_IDLE;
          w_mem_req_nxt    = 1'b0;
          w_pend_valid_nxt = 1'b0;
          // A redirect seen during or at the end of the fetch discards the data.
          if (i_pc_load) begin
            w_pc_nxt          = w_target;
            w_instr_valid_nxt = 1'b0;
          end else if (r_pend_valid) begin
            w_pc_nxt          = r_pend;
            w_instr_valid_nxt = 1'b0;
          end else begin
            w_ir_nxt          = i_mem_rdata;
            w_pc_nxt          = r_mem_addr + c_PC_STEP;
            w_instr_valid_nxt = 1'b1;
          end
        end else begin
          if (i_pc_load) begin
            w_pend_nxt       = w_target;
            w_pend_valid_nxt = 1'b1;
          end
          if (r_timer == c_TMO_LAST) begin
            w_state_nxt   = S_ERR;
            w_mem_req_nxt = 1'b0;
            w_err_nxt     = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
      end

      S_ERR: begin
        w_err_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_ir          = r_ir;
  assign o_op          = r_ir[31:26];
  assign o_pc          = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;

endmodule
`default_nettype wire
